mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequencing controller between the MEM pipeline stage and a handshaked, word-addressed data memory.
- Accepts one load or store per request. Decodes byte, half or word size from opcode/funct3, drives byte enables and lane-shifted write data, and holds the request until the memory acknowledges or a timeout expires.
- Returns sign- or zero-extended load data and flags misaligned or illegal accesses.
- Asserts busy so the hazard unit can stall the pipeline while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 15: cycles REQ may wait for mem_ack before aborting with a bus error. Must be at least 1.
- CNT_W, 4: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  MEM stage presents an access this cycle
- opcode  in  7  instruction opcode; 0000011 = load, 0100011 = store
- funct3  in  3  size/sign select
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- busy  out  1  access in flight; pipeline must stall
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load data; valid while done=1
- misalign  out  1  with done: misaligned address
- illegal  out  1  with done: unsupported funct3
- bus_err  out  1  with done: timeout
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_ack  in  1  memory completion; sampled only while mem_req=1
- mem_rdata  in  32  read word; valid when mem_ack=1

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0, counter 0, internal latches 0. Takes effect mid-access too; mem_req drops immediately.
- States: IDLE, REQ, DONE.
- IDLE:
  - start=1 with opcode load or store: latch opcode, funct3, addr, wdata.
  - Invalid funct3 (store: 011–111; load: 011, 110, 111) -> DONE with illegal=1.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0) -> DONE with misalign=1.
  - Otherwise -> REQ.
  - start with any other opcode: ignored, no outputs.
- REQ:
  - mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are constant throughout REQ.
  - Counter increments each cycle mem_ack=0.
  - mem_ack=1: capture mem_rdata, go to DONE.
  - Counter reaches TIMEOUT_CYCLES with mem_ack=0: go to DONE with bus_err=1. If ack and timeout occur in the same cycle, ack wins.
- DONE:
  - done=1 for exactly one cycle; flag outputs valid in that cycle only.
  - Returns to IDLE. A start in the DONE cycle is ignored; MEM re-presents it in IDLE.
- busy=1 in REQ and DONE, 0 in IDLE.
- Latency: start sampled at edge k -> mem_req high after edge k. With zero-wait ack (ack in first REQ cycle), done is high in cycle k+2. Error paths: done in cycle k+1, no mem_req.
- Byte lane o = addr[1:0]:
  - Byte: mem_be = 0001<<o; mem_wdata = {4{wdata[7:0]}}.
  - Half: mem_be = 0011<<o; mem_wdata = {2{wdata[15:0]}}.
  - Word: mem_be = 1111; mem_wdata = wdata.
  - Loads: mem_be per size, mem_we=0.
- Load extract:
  - Select byte/half at lane o from captured data.
  - funct3 000 / 001: sign-extend.
  - funct3 100 / 101: zero-extend.
  - funct3 010: full word.
  - rdata = 0 for stores and all error paths.
- Outputs are registered; no combinational path from mem_ack to done.

Test Plan:
- SW: addr=0x100, wdata=0xDEADBEEF, ack on 2nd REQ cycle -> mem_addr=0x100, mem_be=1111, mem_we=1, mem_wdata=0xDEADBEEF; done 1 cycle after ack; busy high for 3 cycles.
- SB: addr=0x203, wdata=0x000000A5 -> mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5. Then LB at the same address with mem_rdata=0x80000000 -> rdata=0xFFFFFF80. LBU at the same address -> rdata=0x00000080.
- LH: addr=0x102, mem_rdata=0x8001_1234 -> rdata=0xFFFF8001. LHU -> rdata=0x00008001. LH at addr=0x101 -> misalign=1 and done next cycle, mem_req never asserted.
- Store with funct3=011 -> illegal=1 with done, no mem_req. Opcode 0110011 with start=1 -> no busy, no done.
- mem_ack held 0 -> mem_req high exactly 15 cycles, then done=1, bus_err=1, rdata=0, mem_req=0.
- Reset asserted mid-REQ -> mem_req, busy and done drop asynchronously. After release, a fresh SW completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Sequencing controller between the MEM pipeline stage and a handshaked,
// word-addressed data memory. One load or store is accepted per request; the
// access size comes from funct3. The controller drives byte enables and
// lane-replicated write data. It holds the request until the memory
// acknowledges or the timeout counter expires. It then returns extended load
// data with a one-cycle done pulse.
//
// Handshake: in IDLE a request is taken on any rising edge where start=1 and
// opcode is a load or store; start is ignored in REQ and DONE (busy=1 tells
// the pipeline to stall and re-present). Towards memory, mem_req stays high
// with constant mem_we/mem_addr/mem_be/mem_wdata until the first edge where
// mem_ack=1; mem_ack and mem_rdata are only looked at while mem_req=1.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   MEM stage presents an access this cycle
//   opcode     in   [6:0] 0000011 = load, 0100011 = store
//   funct3     in   [2:0] size/sign select
//   addr       in   [31:0] byte address
//   wdata      in   [31:0] store data, right-justified
//   busy       out  access in flight (REQ or DONE)
//   done       out  one-cycle completion pulse
//   rdata      out  [31:0] extended load data, valid while done=1, else 0
//   misalign   out  with done: misaligned address
//   illegal    out  with done: unsupported funct3
//   bus_err    out  with done: memory did not acknowledge in time
//   mem_req    out  memory request
//   mem_we     out  1 = write
//   mem_addr   out  [31:0] word address {addr[31:2], 2'b00}
//   mem_be     out  [3:0] byte enables
//   mem_wdata  out  [31:0] lane-aligned write data (0 for loads)
//   mem_ack    in   memory completion
//   mem_rdata  in   [31:0] read word, valid with mem_ack
//   dbg_state  out  [1:0] current FSM state (0 IDLE, 1 REQ, 2 DONE)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 15,  // >= 1
    parameter int CNT_W          = 4    // 2**CNT_W > TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        illegal,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched request and result registers.
    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             misalign_q;
    logic             illegal_q;
    logic             bus_err_q;
    logic [CNT_W-1:0] cnt_q;

    // -------------------------------------------------------------------------
    // Incoming request decode (only meaningful in IDLE)
    // -------------------------------------------------------------------------
    logic req_is_load;
    logic req_is_store;
    logic req_valid;
    logic req_illegal;
    logic req_misalign;

    always_comb begin
        req_is_load  = (opcode == OP_LOAD);
        req_is_store = (opcode == OP_STORE);
        req_valid    = start & (req_is_load | req_is_store);

        // Stores support SB/SH/SW only; loads add LBU/LHU.
        if (req_is_store) begin
            req_illegal = funct3[2] | (funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (funct3 == 3'b011) | (funct3 == 3'b110) |
                          (funct3 == 3'b111);
        end

        // Size lives in funct3[1:0] for both signed and unsigned loads.
        req_misalign = ((funct3[1:0] == 2'b01) & addr[0]) |
                       ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    end

    // The last waiting cycle: without an ack on this edge the access aborts.
    logic timeout_hit;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // -------------------------------------------------------------------------
    // Lane steering from the latched request
    // -------------------------------------------------------------------------
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane;
    logic [31:0] rd_shifted;
    logic [31:0] load_ext;

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                be_lane    = 4'b0001 << addr_q[1:0];
                wdata_lane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_lane    = 4'b0011 << addr_q[1:0];
                wdata_lane = {2{wdata_q[15:0]}};
            end
            default: begin
                be_lane    = 4'b1111;
                wdata_lane = wdata_q;
            end
        endcase
    end

    // Move the addressed byte/half down to bit 0; word accesses are aligned,
    // so the shift is zero for them.
    always_comb begin
        rd_shifted = mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_shifted[7]}},  rd_shifted[7:0]};
            3'b001:  load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b010:  load_ext = rd_shifted;
            3'b100:  load_ext = {24'h000000, rd_shifted[7:0]};
            3'b101:  load_ext = {16'h0000,   rd_shifted[15:0]};
            default: load_ext = 32'h0;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = (req_illegal | req_misalign) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack | timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request latch, timeout counter and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= funct3;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        rdata_q    <= 32'h0;
                        // Illegal takes precedence so only one flag is raised.
                        illegal_q  <= req_illegal;
                        misalign_q <= ~req_illegal & req_misalign;
                        bus_err_q  <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        // Ack wins over a simultaneous timeout.
                        rdata_q <= is_store_q ? 32'h0 : load_ext;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (timeout_hit) begin
                            bus_err_q <= 1'b1;
                            rdata_q   <= 32'h0;
                        end
                    end
                end
                S_DONE: begin
                    cnt_q      <= '0;
                    misalign_q <= 1'b0;
                    illegal_q  <= 1'b0;
                    bus_err_q  <= 1'b0;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs, decoded from registers only (no mem_ack path)
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        mem_req   = (state_q == S_REQ);
        rdata     = done ? rdata_q : 32'h0;
        misalign  = done & misalign_q;
        illegal   = done & illegal_q;
        bus_err   = done & bus_err_q;
        mem_we    = mem_req & is_store_q;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_be    = mem_req ? be_lane : 4'b0000;
        mem_wdata = (mem_req & is_store_q) ? wdata_lane : 32'h0;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Lockstep bench: the driver changes inputs on falling edges and, for each
// following rising edge, pushes the complete expected output vector computed
// from the access rules (lane arithmetic, extension by masking). A single
// compare process pops one vector per rising edge and checks every output.
// Directed accesses additionally pin observed values to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int TO = 15;
  localparam int W  = 107;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        illegal;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .misalign(misalign), .illegal(illegal), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  logic [31:0] last_rdata = '0;
  logic [2:0]  last_flags = '0;   // {misalign, illegal, bus_err}
  logic [31:0] last_req_addr = '0;
  logic [31:0] last_req_wdata = '0;
  logic [3:0]  last_req_be = '0;
  logic        last_req_we = 1'b0;
  int req_cycles  = 0;
  int busy_cycles = 0;
  int done_count  = 0;

  logic [6:0] other_ops [5] = '{7'b0110011, 7'b0010011, 7'b1100011,
                                7'b0000000, 7'b1101111};
  logic [2:0] load_f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  function automatic logic [W-1:0] pack(
    input logic b, input logic d, input logic [31:0] rd,
    input logic mi, input logic il, input logic be_, input logic rq,
    input logic we, input logic [31:0] ad, input logic [3:0] bn,
    input logic [31:0] wd);
    return {b, d, rd, mi, il, be_, rq, we, ad, bn, wd};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: one expected vector per rising edge
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin : cmp_proc
    logic [W-1:0] e_v;
    logic [W-1:0] a_v;
    #1;
    if (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      a_v = pack(busy, done, rdata, misalign, illegal, bus_err, mem_req,
                 mem_we, mem_addr, mem_be, mem_wdata);
      n_tests++;
      if (a_v !== e_v) begin
        n_fail++;
        $display("FAIL outputs t=%0t got {busy,done,rdata,mis,ill,berr,req,we,addr,be,wdata}=%h expected %h",
                 $time, a_v, e_v);
      end
      if (mem_req) begin
        req_cycles++;
        last_req_addr  = mem_addr;
        last_req_wdata = mem_wdata;
        last_req_be    = mem_be;
        last_req_we    = mem_we;
      end
      if (busy) busy_cycles++;
      if (done) begin
        done_count++;
        last_rdata = rdata;
        last_flags = {misalign, illegal, bus_err};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // A legal-looking request that must be ignored because the block is busy.
  task automatic noise_start();
    start  = 1'($urandom_range(0, 1));
    opcode = ($urandom_range(0, 1) == 0) ? OP_LOAD : OP_STORE;
    funct3 = 3'($urandom_range(0, 2));
    addr   = $urandom;
    wdata  = $urandom;
  endtask

  task automatic idle_cycle();
    start     = 1'($urandom_range(0, 1));
    opcode    = other_ops[$urandom_range(0, 4)];
    funct3    = 3'($urandom_range(0, 7));
    addr      = $urandom;
    wdata     = $urandom;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    exp_q.push_back('0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issue one request at a falling edge; returns at the falling edge after
  // the block is back in IDLE. ack_delay = index of the REQ cycle that sees
  // mem_ack (>= TO means never).
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rword, input int ack_delay);
    bit is_ld, is_st, ill, mis;
    int n, o;
    logic [3:0]  be;
    logic [31:0] lane_wd, mask, ext;
    logic [W-1:0] v_req;

    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    o     = int'(a[1:0]);
    n     = 1 << f3[1:0];
    if (is_st) ill = !(f3 inside {3'd0, 3'd1, 3'd2});
    else       ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = !ill && ((o % n) != 0);

    be = '0;
    lane_wd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= o && i < o + n) be[i] = 1'b1;
      if (is_st) lane_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    end

    mask = (n >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    ext  = (rword >> (8 * o)) & mask;
    if (!f3[2] && n < 4 && ext[8*n-1]) ext = ext | ~mask;
    if (is_st) ext = '0;

    v_req = pack(1, 0, 0, 0, 0, 0, 1, is_st, {a[31:2], 2'b00}, be, lane_wd);

    start     = 1'b1;
    opcode    = op;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;

    if (!(is_ld || is_st)) begin
      exp_q.push_back('0);
      @(negedge clk);
      start = 1'b0;
      return;
    end

    if (ill || mis) begin
      exp_q.push_back(pack(1, 1, 0, mis, ill, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
    end else begin
      exp_q.push_back(v_req);
      @(negedge clk);
      for (int j = 0; j < TO; j++) begin
        noise_start();
        mem_ack   = (j == ack_delay);
        mem_rdata = (j == ack_delay) ? rword : $urandom;
        if (j == ack_delay) begin
          exp_q.push_back(pack(1, 1, ext, 0, 0, 0, 0, 0, 0, 0, 0));
          break;
        end else if (j == TO - 1) begin
          exp_q.push_back(pack(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
          break;
        end
        exp_q.push_back(v_req);
        @(negedge clk);
      end
      @(negedge clk);
    end

    // DONE cycle: a request presented now must be dropped.
    noise_start();
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    exp_q.push_back('0);
    @(negedge clk);
    start   = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic reset_mid_req();
    start   = 1'b1;
    opcode  = OP_LOAD;
    funct3  = 3'b010;
    addr    = 32'h0000_0040;
    wdata   = '0;
    mem_ack = 1'b0;
    exp_q.push_back(pack(1, 0, 0, 0, 0, 0, 1, 0, 32'h40, 4'hF, 0));
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back(pack(1, 0, 0, 0, 0, 0, 1, 0, 32'h40, 4'hF, 0));
      @(negedge clk);
    end
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    exp_q.push_back('0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_mem_req", 32'(mem_req), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    @(negedge clk);
    exp_q.push_back('0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int b0, r0, d0;
    logic [6:0]  op;
    logic [2:0]  f3;
    int          dly;

    reset = 1'b1; start = 1'b0; opcode = '0; funct3 = '0; addr = '0;
    wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #1 reset = 1'b0;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_be", 32'(mem_be), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);

    // SW, ack on the 2nd REQ cycle
    b0 = busy_cycles; r0 = req_cycles;
    run_txn(OP_STORE, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 1);
    check("sw_addr", last_req_addr, 32'h100);
    check("sw_be", 32'(last_req_be), 32'hF);
    check("sw_we", 32'(last_req_we), 32'd1);
    check("sw_wdata", last_req_wdata, 32'hDEAD_BEEF);
    check("sw_busy_cycles", 32'(busy_cycles - b0), 32'd3);
    check("sw_req_cycles", 32'(req_cycles - r0), 32'd2);

    // SB to the top lane
    run_txn(OP_STORE, 3'b000, 32'h203, 32'h0000_00A5, 32'h0, 0);
    check("sb_addr", last_req_addr, 32'h200);
    check("sb_be", 32'(last_req_be), 32'h8);
    check("sb_wdata", last_req_wdata, 32'hA5A5_A5A5);

    run_txn(OP_LOAD, 3'b000, 32'h203, 32'h0, 32'h8000_0000, 0);
    check("lb_rdata", last_rdata, 32'hFFFF_FF80);
    run_txn(OP_LOAD, 3'b100, 32'h203, 32'h0, 32'h8000_0000, 2);
    check("lbu_rdata", last_rdata, 32'h0000_0080);
    run_txn(OP_LOAD, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 0);
    check("lh_rdata", last_rdata, 32'hFFFF_8001);
    run_txn(OP_LOAD, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 0);
    check("lhu_rdata", last_rdata, 32'h0000_8001);

    // Misaligned half: done next cycle, never requests
    r0 = req_cycles; d0 = done_count;
    run_txn(OP_LOAD, 3'b001, 32'h101, 32'h0, 32'h0, 0);
    check("lh_mis_flags", 32'(last_flags), 32'h4);
    check("lh_mis_req_cycles", 32'(req_cycles - r0), 32'd0);
    check("lh_mis_done", 32'(done_count - d0), 32'd1);

    // Illegal store size
    r0 = req_cycles;
    run_txn(OP_STORE, 3'b011, 32'h100, 32'h1234_5678, 32'h0, 0);
    check("st_ill_flags", 32'(last_flags), 32'h2);
    check("st_ill_req_cycles", 32'(req_cycles - r0), 32'd0);

    // Non-memory opcode is ignored
    b0 = busy_cycles; d0 = done_count;
    run_txn(7'b0110011, 3'b010, 32'h100, 32'h0, 32'h0, 0);
    check("other_op_busy", 32'(busy_cycles - b0), 32'd0);
    check("other_op_done", 32'(done_count - d0), 32'd0);

    // Timeout: no ack at all
    r0 = req_cycles;
    run_txn(OP_LOAD, 3'b010, 32'h300, 32'h0, 32'hFFFF_FFFF, 100);
    check("timeout_req_cycles", 32'(req_cycles - r0), 32'd15);
    check("timeout_flags", 32'(last_flags), 32'h1);
    check("timeout_rdata", last_rdata, 32'h0);

    // Ack on the last allowed cycle beats the timeout
    r0 = req_cycles;
    run_txn(OP_LOAD, 3'b010, 32'h304, 32'h0, 32'h1234_5678, TO - 1);
    check("late_ack_req_cycles", 32'(req_cycles - r0), 32'd15);
    check("late_ack_flags", 32'(last_flags), 32'h0);
    check("late_ack_rdata", last_rdata, 32'h1234_5678);

    // Reset during REQ, then a fresh SW
    reset_mid_req();
    d0 = done_count;
    run_txn(OP_STORE, 3'b010, 32'h100, 32'hCAFE_F00D, 32'h0, 0);
    check("post_reset_sw_done", 32'(done_count - d0), 32'd1);
    check("post_reset_sw_wdata", last_req_wdata, 32'hCAFE_F00D);
    check("post_reset_sw_flags", 32'(last_flags), 32'h0);

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      int kind;
      kind = $urandom_range(0, 99);
      if (kind < 45)      op = OP_LOAD;
      else if (kind < 90) op = OP_STORE;
      else                op = other_ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (op == OP_STORE)       f3 = 3'($urandom_range(0, 2));
      else                           f3 = load_f3s[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0:       dly = 100;
        1:       dly = TO - 1;
        2:       dly = TO;
        default: dly = $urandom_range(0, 4);
      endcase
      run_txn(op, f3, $urandom, $urandom, $urandom, dly);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    finish_run();
  end

  initial begin : watchdog
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: run did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
